// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory wait-state generator.
// Holds the default LATENCY/DEPTH/ADDR_W values, the countdown width helper
// and the slot record (address + countdown) at the default sizing.
package riscv_mem_pkg;

   localparam int unsigned DefaultLatency = 3;
   localparam int unsigned DefaultDepth   = 2;
   localparam int unsigned DefaultAddrW   = 64;

   // Countdown width: $clog2(LATENCY), never narrower than one bit.
   function automatic int unsigned cnt_width(int unsigned latency);
      return (latency > 1) ? $clog2(latency) : 1;
   endfunction

   typedef struct packed {
      logic [DefaultAddrW-1:0]                addr;
      logic [cnt_width(DefaultLatency)-1:0]   cnt;
   } slot_t;

endpackage

// File: rtl/riscv_mem_wait_gen_if.sv
// Request/response bundle between a requester (fetch/LSU) and the wait-state
// generator.
//   req_valid/req_addr/req_ready : read request handshake
//   flush                        : synchronous cancel of outstanding requests
//   rsp_valid/rsp_addr           : one-cycle completion pulse with its address
//   busy                         : at least one request outstanding
interface riscv_mem_wait_gen_if
   import riscv_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = DefaultAddrW
) ();

   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              flush;
   logic              rsp_valid;
   logic [ADDR_W-1:0] rsp_addr;
   logic              busy;

   modport master (
      output req_valid, req_addr, flush,
      input  req_ready, rsp_valid, rsp_addr, busy
   );

   modport slave (
      input  req_valid, req_addr, flush,
      output req_ready, rsp_valid, rsp_addr, busy
   );

endinterface

// File: rtl/riscv_mem_wait_slot.sv
// One queue slot: holds a request address and its remaining-latency countdown.
//   clk       : clock
//   load_i    : capture addr_i and restart the countdown at LATENCY-1
//   addr_i    : address to capture
//   dec_i     : slot is occupied; count down one step (saturating at zero)
//   addr_o    : stored address
//   is_zero_o : countdown has expired
// Contents are don't-care while unoccupied, so the slot carries no reset.
module riscv_mem_wait_slot
   import riscv_mem_pkg::*;
#(
   parameter int unsigned LATENCY = DefaultLatency,
   parameter int unsigned ADDR_W  = DefaultAddrW
) (
   input  logic              clk,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              dec_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              is_zero_o
);

   localparam int unsigned     CntW    = cnt_width(LATENCY);
   localparam logic [CntW-1:0] LoadVal = CntW'(LATENCY - 1);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   always_comb begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         addr_d = addr_i;
         cnt_d  = LoadVal;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
   end

   assign addr_o    = addr_q;
   assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/riscv_mem_wait_gen.sv
// Fixed-latency wait-state generator for the core memory ports.
// Accepts read requests on a valid/ready handshake and returns each one,
// in order, LATENCY edges after acceptance; up to DEPTH may be outstanding.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of riscv_mem_wait_gen_if (request, flush, response, busy)
module riscv_mem_wait_gen
   import riscv_mem_pkg::*;
#(
   parameter int unsigned LATENCY = DefaultLatency,
   parameter int unsigned DEPTH   = DefaultDepth,
   parameter int unsigned ADDR_W  = DefaultAddrW
) (
   input logic                 clk,
   input logic                 rst_n,
   riscv_mem_wait_gen_if.slave bus
);

   localparam int unsigned       PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned       CountW    = $clog2(DEPTH + 1);
   localparam logic [PtrW-1:0]   LastPtr   = PtrW'(DEPTH - 1);
   localparam logic [CountW-1:0] FullCount = CountW'(DEPTH);

   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CountW-1:0] count_q, count_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
   logic              busy_q, busy_d;

   logic [DEPTH-1:0]  slot_load, slot_dec, slot_zero;
   logic [ADDR_W-1:0] slot_addr [DEPTH];
   logic              head_zero;
   logic [ADDR_W-1:0] head_addr;
   logic              push, pop, ready;

   function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrW'(1);
   endfunction

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      assign slot_load[g] = push && (wr_ptr_q == PtrW'(g));

      riscv_mem_wait_slot #(
         .LATENCY (LATENCY),
         .ADDR_W  (ADDR_W)
      ) u_slot (
         .clk       (clk),
         .load_i    (slot_load[g]),
         .addr_i    (bus.req_addr),
         .dec_i     (slot_dec[g]),
         .addr_o    (slot_addr[g]),
         .is_zero_o (slot_zero[g])
      );
   end

   // Head selection and occupancy. Occupied slots run from rd_ptr up to (not
   // including) wr_ptr, wrapping; equal pointers mean empty unless full.
   always_comb begin
      head_zero = 1'b0;
      head_addr = '0;
      slot_dec  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (rd_ptr_q == PtrW'(i)) begin
            head_zero = slot_zero[i];
            head_addr = slot_addr[i];
         end
         if (count_q == FullCount) begin
            slot_dec[i] = 1'b1;
         end else if (rd_ptr_q <= wr_ptr_q) begin
            slot_dec[i] = (PtrW'(i) >= rd_ptr_q) && (PtrW'(i) < wr_ptr_q);
         end else begin
            slot_dec[i] = (PtrW'(i) >= rd_ptr_q) || (PtrW'(i) < wr_ptr_q);
         end
      end
   end

   always_comb begin
      pop   = (count_q != '0) && head_zero;
      // A full queue still accepts when its head leaves on the same edge.
      ready = !bus.flush && ((count_q < FullCount) || pop);
      push  = bus.req_valid && ready;

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rsp_valid_d = 1'b0;
      rsp_addr_d  = rsp_addr_q;

      if (bus.flush) begin
         // A head that would pop here is dropped without a response.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop) begin
            rd_ptr_d    = ptr_inc(rd_ptr_q);
            rsp_valid_d = 1'b1;
            rsp_addr_d  = head_addr;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CountW'(1);
            2'b01:   count_d = count_q - CountW'(1);
            default: count_d = count_q;
         endcase
      end

      busy_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_addr_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_addr_q  <= rsp_addr_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_addr  = rsp_addr_q;
   assign bus.busy      = busy_q;

endmodule

// File: doc/riscv_mem_wait_gen.md
# riscv_mem_wait_gen

Parametrised wait-state generator for the core's memory ports, the successor to the single-request iram ready counter. It accepts read requests on a valid/ready handshake and returns each one after a fixed, parametrised number of cycles, with its address, strictly in order. Up to DEPTH requests may be outstanding, so back-to-back fetches pipeline instead of serialising. It sits between the fetch/LSU request logic and the instruction or data RAM model and drives the memory-ready indication those stages already consume.

## Interface
- LATENCY, 3: edges from the accepting edge to the `rsp_valid` edge; legal range ≥1. Default 3 matches the current iram timing.
- DEPTH, 2: maximum number of outstanding requests; legal range ≥1.
- ADDR_W, 64: request address width.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  read request (replaces `rden`).
- req_addr  in  ADDR_W  request address.
- req_ready  out  1  combinational; the request is accepted on an edge where `req_valid && req_ready`.
- flush  in  1  synchronous cancel of all outstanding requests.
- rsp_valid  out  1  registered one-cycle completion pulse (replaces `mem_ready`).
- rsp_addr  out  ADDR_W  registered address of the completing request.
- busy  out  1  registered; 1 while at least one request is outstanding.

## Operation
- Storage is a circular queue of DEPTH slots. Each slot holds an address and a countdown of width $clog2(LATENCY) (minimum 1 bit).
- Queue control uses `wr_ptr`, `rd_ptr` and `count` (width $clog2(DEPTH+1)). Pointers wrap from DEPTH-1 to 0.
- On accept, the slot at `wr_ptr` is loaded with `req_addr` and countdown LATENCY-1.
- Every edge, each occupied slot with countdown >0 decrements. Countdowns saturate at 0.
- Pop condition: `count != 0` and head countdown == 0.
  - On pop: `rsp_valid <= 1`, `rsp_addr <=` head address, `rd_ptr` advances.
  - Otherwise `rsp_valid <= 0` and `rsp_addr` holds its value.
- `req_ready = !flush && (count < DEPTH || pop)`. When full and popping in the same edge, push and pop coincide and `count` is unchanged.
- Fixed latency keeps completions in order, at most one per cycle.
- `busy <=` (next `count` != 0).
- Flush edge:
  - `count`, `wr_ptr` and `rd_ptr` clear to 0 and `rsp_valid <= 0`.
  - A request presented in the same cycle is not accepted.
  - A head that would have popped is discarded and gets no response.
- Reset edge: same effect as flush, plus `rsp_addr <= 0` and `busy <= 0`. Slot contents are don't-care.

## Timing
- Reset values: `rsp_valid`=0, `rsp_addr`=0, `busy`=0. `req_ready`=1 in the first cycle after reset when `flush`=0.
- Request accepted at edge k → `rsp_valid`=1 for exactly the cycle following edge k+LATENCY.
- `req_valid` does not need to be held after acceptance.
- Throughput is one request per cycle iff DEPTH ≥ LATENCY. Otherwise accepts stall until the head pops.
- LATENCY=1: the response follows one edge after accept. With DEPTH=1 the block still sustains one request per cycle through simultaneous push/pop.
- Reset and flush take effect at the sampling edge. Outputs show the cleared state in the next cycle, including mid-countdown.

## Structure
- Shared package `riscv_mem_pkg`: default LATENCY/DEPTH constants and the slot type (addr + countdown).
- One sub-module, `riscv_mem_wait_slot`: a single slot with load, decrement, saturate and `is_zero`. The top level generates DEPTH instances plus the queue pointers and output registers.

## Test plan
- Reset: hold `rst_n`=0 with `req_valid`=1 → `rsp_valid`=0, `busy`=0, `rsp_addr`=0. After release, `req_ready`=1.
- Single request, LATENCY=3: `req_addr`=0x1000 accepted at edge 0 → `rsp_valid` high only after edge 3, `rsp_addr`=0x1000, `busy` low after edge 3.
- Streaming, LATENCY=3, DEPTH=2: `req_valid` held with addrs A0, A1, … → accepts at edges 0,1,3,4,6; responses at 3,4,6,7,9 in address order; `req_ready`=0 before edges 2 and 5.
- Full throughput, LATENCY=3, DEPTH=3: 8 consecutive requests → 8 consecutive `rsp_valid` pulses at edges 3..10, no stall.
- Flush: two requests outstanding, `flush` at edge 2 together with a new request → no responses ever, `busy`=0 after edge 2, new request dropped. Next accept at edge 3 responds at edge 6.
- Mid-operation reset plus LATENCY=1, DEPTH=1: reset at edge 1 after an accept at edge 0 → no response. Then back-to-back accepts at edges 5,6,7 → responses at 6,7,8.
